// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage pipelined subtractor (diff = a - b) with borrow/overflow/zero flags
//   clk, rst_n (async active-low)
//   i_a, i_b       minuend / subtrahend
//   i_in_valid     operands valid;  o_in_ready  block accepts operands this cycle
//   o_diff         a - b mod 2^WIDTH; o_borrow unsigned a < b; o_overflow signed overflow
//   o_zero         diff == 0;       o_out_valid result valid; i_out_ready consumer accepts
module sub32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_out_valid,
  input  logic             i_out_ready
);
  localparam int H = WIDTH / 2;
  logic         r_s1_valid;
  logic [H-1:0] r_lo;
  logic         r_ch;
  logic [H-1:0] r_a_hi;
  logic [H-1:0] r_b_hi;
  logic         r_a_msb;
  logic         r_b_msb;
  logic         w_s2_ready;
  logic         w_accept;
  logic         w_move;
  logic [H:0]   w_lo_sum;
  logic [H:0]   w_hi_sum;
  logic [WIDTH-1:0] w_diff;
  assign w_s2_ready = !o_out_valid || i_out_ready;
  assign o_in_ready = !r_s1_valid || w_s2_ready;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_move     = r_s1_valid && w_s2_ready;
  // subtraction as a + ~b + 1: the +1 enters as carry-in of the low half
  assign w_lo_sum = {1'b0, i_a[H-1:0]} + {1'b0, ~i_b[H-1:0]} + {{H{1'b0}}, 1'b1};
  // high half consumes the registered low-half carry
  assign w_hi_sum = {1'b0, r_a_hi} + {1'b0, ~r_b_hi} + {{H{1'b0}}, r_ch};
  assign w_diff   = {w_hi_sum[H-1:0], r_lo};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_ch       <= 1'b0;
      r_a_hi     <= '0;
      r_b_hi     <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else begin
      r_s1_valid <= w_accept ? 1'b1 : (w_move ? 1'b0 : r_s1_valid);
      if (w_accept) begin
        r_lo    <= w_lo_sum[H-1:0];
        r_ch    <= w_lo_sum[H];
        r_a_hi  <= i_a[WIDTH-1:H];
        r_b_hi  <= i_b[WIDTH-1:H];
        r_a_msb <= i_a[WIDTH-1];
        r_b_msb <= i_b[WIDTH-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_diff      <= '0;
      o_borrow    <= 1'b0;
      o_overflow  <= 1'b0;
      o_zero      <= 1'b0;
    end else begin
      o_out_valid <= w_move ? 1'b1 : (i_out_ready ? 1'b0 : o_out_valid);
      if (w_move) begin
        o_diff     <= w_diff;
        o_borrow   <= ~w_hi_sum[H];
        o_overflow <= (r_a_msb != r_b_msb) && (w_hi_sum[H-1] != r_a_msb);
        o_zero     <= (w_diff == '0);
      end
    end
  end
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: scoreboard bench for sub32_pipe
module tb_sub32_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        o_in_ready, o_borrow, o_overflow, o_zero, o_out_valid;
  logic [31:0] o_diff;
  typedef struct packed {
    logic [31:0] d;
    logic        bw;
    logic        ov;
    logic        z;
  } res_t;
  res_t q[$];
  int n_vec = 0;
  int n_err = 0;
  sub32_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_a(a), .i_b(b), .i_in_valid(in_valid),
    .o_in_ready(o_in_ready), .o_diff(o_diff), .o_borrow(o_borrow),
    .o_overflow(o_overflow), .o_zero(o_zero), .o_out_valid(o_out_valid),
    .i_out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] t;
    t = {1'b0, x} - {1'b0, y};
    model.d  = t[31:0];
    model.bw = t[32];
    model.ov = (x[31] != y[31]) && (t[31] != x[31]);
    model.z  = (t[31:0] == 32'd0);
  endfunction
  task automatic tick(output bit acc);
    res_t e;
    #1;
    if (o_out_valid && out_ready) begin
      check("q_nonempty", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("diff", o_diff, e.d);
        check("borrow", {31'd0, o_borrow}, {31'd0, e.bw});
        check("overflow", {31'd0, o_overflow}, {31'd0, e.ov});
        check("zero", {31'd0, o_zero}, {31'd0, e.z});
      end
    end
    acc = in_valid && o_in_ready;
    if (acc) q.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] x, input logic [31:0] y, output bit first_rdy);
    bit acc;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick(acc);
    first_rdy = acc;
    for (int k = 0; k < 20 && !acc; k++) tick(acc);
    if (!acc) check("send_acc", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    bit acc, r;
    logic [31:0] xs[6], ys[6];
    int idx;
    repeat (2) @(negedge clk);
    check("rst_ov", {31'd0, o_out_valid}, 32'd0);
    check("rst_diff", o_diff, 32'd0);
    check("rst_flags", {29'd0, o_borrow, o_overflow, o_zero}, 32'd0);
    rst_n = 1'b1;
    #1 check("rst_rdy", {31'd0, o_in_ready}, 32'd1);
    @(negedge clk);
    send(32'd5, 32'd3, r);
    check("lat_early", {31'd0, o_out_valid}, 32'd0);
    tick(acc);
    check("lat_2", {31'd0, o_out_valid}, 32'd1);
    check("lat_diff", o_diff, 32'd2);
    idle(2);
    send(32'h0001_0000, 32'h1, r);
    send(32'h0, 32'h1, r);
    send(32'h8000_0000, 32'h1, r);
    send(32'h1234_5678, 32'h1234_5678, r);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, r);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, r);
      check("stream_rdy", {31'd0, r}, 32'd1);
      if (i >= 1) check("stream_ov", {31'd0, o_out_valid}, 32'd1);
    end
    idle(4);
    check("q_empty1", q.size(), 32'd0);
    for (int i = 0; i < 6; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      a = xs[idx];
      b = ys[idx];
      in_valid = 1'b1;
      tick(acc);
      if (acc) idx++;
    end
    check("bp_accepts", idx, 32'd2);
    #1 check("bp_rdy", {31'd0, o_in_ready}, 32'd0);
    check("bp_hold", o_diff, model(xs[0], ys[0]).d);
    check("bp_ov", {31'd0, o_out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && idx < 6; k++) begin
      a = xs[idx];
      b = ys[idx];
      in_valid = 1'b1;
      tick(acc);
      if (acc) idx++;
    end
    check("bp_all", idx, 32'd6);
    idle(4);
    check("q_empty2", q.size(), 32'd0);
    out_ready = 1'b0;
    send(32'hAAAA_0000, 32'h1, r);
    send(32'h0000_0010, 32'h3, r);
    check("pre_rst_ov", {31'd0, o_out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", {31'd0, o_out_valid}, 32'd0);
    check("mid_rst_diff", o_diff, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      check("no_stale", {31'd0, o_out_valid}, 32'd0);
    end
    send(32'h0, 32'h0, r);
    idle(3);
    check("q_empty3", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
